// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the bit-serial shift sequencer: state encoding and direction codes.
package shift_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/done handshake and operand/result bus of the shift sequencer.
// The rotate signal exists only when SHIFT_ROTATE_EN is defined.
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             dir;
    logic             arith;
`ifdef SHIFT_ROTATE_EN
    logic             rotate;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

`ifdef SHIFT_ROTATE_EN
    modport master (output start, operand, amount, dir, arith, rotate,
                    input  busy, done, result, carry_out);
    modport slave  (input  start, operand, amount, dir, arith, rotate,
                    output busy, done, result, carry_out);
`else
    modport master (output start, operand, amount, dir, arith,
                    input  busy, done, result, carry_out);
    modport slave  (input  start, operand, amount, dir, arith,
                    output busy, done, result, carry_out);
`endif

endinterface

// File: rtl/shift_sequencer_step.sv
// Single-bit combinational shift step: moves val one place in dir, inserting fill.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] val,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] val_next,
    output logic             bit_out
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            val_next = {fill, val[WIDTH-1:1]};
            bit_out  = val[0];
        end else begin
            val_next = {val[WIDTH-2:0], fill};
            bit_out  = val[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter, one bit per clock, with start/done handshake.
// Optional rotate mode is compiled in with SHIFT_ROTATE_EN.
//
//   state | meaning
//   IDLE  | waiting for start; result/carry_out hold last value
//   SHIFT | one bit shifted per cycle while count > 0
//   DONE  | one-cycle done pulse; start still ignored here
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_sequencer_if.slave bus
);

    state_t           state, state_nxt;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             dir_q;
    logic             arith_q;
    logic             rot_q;
    logic             fill;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             accept;

    assign accept = (state == IDLE) && bus.start;

    // Rotate feeds the outgoing bit back in; otherwise only arithmetic right shifts sign-fill.
    always_comb begin
        fill = 1'b0;
        if (rot_q)
            fill = (dir_q == DIR_RIGHT) ? result[0] : result[WIDTH-1];
        else if (dir_q == DIR_RIGHT && arith_q)
            fill = result[WIDTH-1];
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .val      (result),
        .dir      (dir_q),
        .fill     (fill),
        .val_next (step_val),
        .bit_out  (step_bit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (bus.amount == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (count == AMT_W'(1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            dir_q     <= DIR_LEFT;
            arith_q   <= 1'b0;
            rot_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                result    <= bus.operand;
                count     <= bus.amount;
                carry_out <= 1'b0;
                dir_q     <= bus.dir;
                arith_q   <= bus.arith;
`ifdef SHIFT_ROTATE_EN
                rot_q     <= bus.rotate;
`else
                rot_q     <= 1'b0;
`endif
            end else if (state == SHIFT) begin
                result    <= step_val;
                carry_out <= step_bit;
                count     <= count - AMT_W'(1);
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result;
    assign bus.carry_out = carry_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, randomized ops against an
// arithmetic reference model, restart-while-busy and mid-operation reset sequences.
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic clk;
    logic rst_n;

    int tests_run = 0;
    int tests_failed = 0;

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] operand;
        int          amount;
        logic        dir;
        logic        arith;
        logic        rot;
        logic [15:0] exp_result;
        logic        exp_carry;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word shift/rotate by amt, carry = the last original bit to leave.
    function automatic void model(input logic [15:0] op, input int amt, input logic d,
                                  input logic ar, input logic ro,
                                  output logic [15:0] r, output logic c);
        logic [31:0] w;
        logic        rot_eff;
`ifdef SHIFT_ROTATE_EN
        rot_eff = ro;
`else
        rot_eff = 1'b0;
`endif
        w = {16'h0000, op};
        if (amt == 0) begin
            r = op;
            c = 1'b0;
        end else if (d == 1'b0) begin
            c = w[16 - amt];
            if (rot_eff) r = 16'((w << amt) | (w >> (16 - amt)));
            else         r = 16'(w << amt);
        end else begin
            c = w[amt - 1];
            if (rot_eff)  r = 16'((w >> amt) | (w << (16 - amt)));
            else if (ar)  r = 16'($signed({{16{op[15]}}, op}) >>> amt);
            else          r = 16'(w >> amt);
        end
    endfunction

    task automatic drive_inputs(input logic [15:0] op, input int amt, input logic d,
                                input logic ar, input logic ro);
        bus.operand = op;
        bus.amount  = AMT_W'(amt);
        bus.dir     = d;
        bus.arith   = ar;
`ifdef SHIFT_ROTATE_EN
        bus.rotate  = ro;
`endif
    endtask

    // Called right after a negedge with the DUT idle; returns right after a negedge, idle.
    task automatic run_op(input string tag, input logic [15:0] op, input int amt,
                          input logic d, input logic ar, input logic ro,
                          input logic [15:0] exp_r, input logic exp_c);
        int lat;
        bit seen;
        bit busy_ok;
        drive_inputs(op, amt, d, ar, ro);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drive_inputs(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                     1'($urandom), 1'($urandom));
        seen = 0;
        lat = 0;
        busy_ok = 1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (!bus.busy) busy_ok = 0;
            if (bus.done) begin
                seen = 1;
                lat = i;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, " latency"}, 32'(lat), 32'(amt + 1));
        check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, " result"}, 32'(bus.result), 32'(exp_r));
        check({tag, " carry"}, 32'(bus.carry_out), 32'(exp_c));
        @(negedge clk);
        check({tag, " done_pulse_1cyc"}, 32'(bus.done), 32'd0);
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, " result_hold"}, 32'(bus.result), 32'(exp_r));
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] mr;
        logic        mc;
        int          ndone;
        bit          got;

        bus.start = 1'b0;
        drive_inputs(16'h0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset carry", 32'(bus.carry_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back('{16'h0001, 4,  1'b0, 1'b0, 1'b0, 16'h0010, 1'b0});
        vecs.push_back('{16'h8001, 1,  1'b0, 1'b0, 1'b0, 16'h0002, 1'b1});
        vecs.push_back('{16'h8001, 0,  1'b0, 1'b0, 1'b0, 16'h8001, 1'b0});
        vecs.push_back('{16'hF000, 4,  1'b1, 1'b1, 1'b0, 16'hFF00, 1'b0});
        vecs.push_back('{16'hF000, 4,  1'b1, 1'b0, 1'b0, 16'h0F00, 1'b0});
        vecs.push_back('{16'h0002, 15, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h4000, 15, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h00FF, 8,  1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0});
        vecs.push_back('{16'h8000, 0,  1'b1, 1'b1, 1'b0, 16'h8000, 1'b0});
`ifdef SHIFT_ROTATE_EN
        vecs.push_back('{16'h8001, 1,  1'b0, 1'b0, 1'b1, 16'h0003, 1'b1});
        vecs.push_back('{16'h8001, 1,  1'b1, 1'b1, 1'b1, 16'hC000, 1'b1});
`endif
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].operand, vecs[i].amount, vecs[i].dir,
                   vecs[i].arith, vecs[i].rot, vecs[i].exp_result, vecs[i].exp_carry);

        for (int n = 0; n < 150; n++) begin
            logic [15:0] op;
            int          amt;
            logic        d, ar, ro;
            op  = 16'($urandom);
            amt = int'($urandom_range(0, 15));
            d   = 1'($urandom);
            ar  = 1'($urandom);
            ro  = 1'($urandom);
            model(op, amt, d, ar, ro, mr, mc);
            run_op($sformatf("rand%0d", n), op, amt, d, ar, ro, mr, mc);
        end

        // Start held high with a different operand through SHIFT and DONE must be ignored.
        drive_inputs(16'h0001, 4, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        drive_inputs(16'hFFFF, 0, 1'b1, 1'b1, 1'b1);
        ndone = 0;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                got = 1;
            end else if (got) begin
                bus.start = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("restart done_count", 32'(ndone), 32'd1);
        check("restart result", 32'(bus.result), 32'h0010);
        check("restart carry", 32'(bus.carry_out), 32'd0);
        check("restart busy", 32'(bus.busy), 32'd0);

        // Reset two cycles into a long operation discards it without a done pulse.
        drive_inputs(16'h1234, 10, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset result", 32'(bus.result), 32'd0);
        check("midreset carry", 32'(bus.carry_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("midreset no_done", 32'(ndone), 32'd0);
        model(16'hF0F1, 3, 1'b1, 1'b1, 1'b0, mr, mc);
        run_op("post_reset", 16'hF0F1, 3, 1'b1, 1'b1, 1'b0, mr, mc);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
